// File: rtl/fir_pkg.sv
// Shared helpers for the transposed-form FIR: address sizing and the
// output round/saturate stage, evaluated in a wide signed domain.
package fir_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t y;
  } sat_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Round half up by adding half an LSB before the arithmetic shift, then
  // clamp to the signed yw-bit range.
  function automatic sat_res_t sat_round(input wide_t acc, input int shift, input int yw);
    wide_t    r;
    wide_t    hi;
    wide_t    lo;
    sat_res_t res;
    r = acc;
    if (shift > 0) r = (acc + (wide_t'(1) <<< (shift - 1))) >>> shift;
    hi = (wide_t'(1) <<< (yw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (yw - 1));
    res.sat = 1'b0;
    res.y   = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.y   = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.y   = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_tf_tap.sv
// One transposed-form FIR tap: coefficient register, multiplier, adder and
// an enabled accumulator register.
module fir_tf_tap #(
  parameter int XW = 8,
  parameter int CW = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 coef_we,
  input  logic signed [CW-1:0] coef_wdata,
  input  logic signed [XW-1:0] x_in,
  input  logic signed [AW-1:0] acc_in,
  output logic signed [AW-1:0] acc_out
);

  logic signed [CW-1:0]    coef;
  logic signed [XW+CW-1:0] prod;
  logic signed [AW-1:0]    sum;

  assign prod = (XW+CW)'(coef) * (XW+CW)'(x_in);
  assign sum  = acc_in + AW'(prod);

  // The product uses the coefficient held before any same-edge write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef    <= '0;
      acc_out <= '0;
    end else begin
      if (coef_we) coef <= coef_wdata;
      if (clear)   acc_out <= '0;
      else if (en) acc_out <= sum;
    end
  end

endmodule

// File: rtl/fir_tf_stream.sv
// Coefficient-programmable transposed-form FIR with valid/ready streaming,
// rounded and saturated output, and stall-on-backpressure.
module fir_tf_stream
  import fir_pkg::*;
#(
  parameter int N_TAPS = 8,
  parameter int XW     = 8,
  parameter int CW     = 8,
  parameter int YW     = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       coef_we,
  input  logic [clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_wdata,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [XW-1:0]       x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [YW-1:0]       y_out,
  output logic                       sat_flag
);

  localparam int AW = XW + CW + clog2(N_TAPS);

  typedef logic signed [AW-1:0] acc_t;

  acc_t              acc [N_TAPS+1];
  logic [N_TAPS-1:0] tap_we;
  logic              fire;
  sat_res_t          res;
  logic              unused_hi;

  assign in_ready    = !clear && (!out_valid || out_ready);
  assign fire        = in_valid && in_ready;
  assign acc[N_TAPS] = '0;

  // acc[0] is tap 0's register: it holds acc[1] + c[0]*x of the last fire,
  // so it doubles as the pre-rounding output register and freezes on stall.
  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    assign tap_we[k] = coef_we && (32'(coef_addr) == k);

    fir_tf_tap #(
      .XW (XW),
      .CW (CW),
      .AW (AW)
    ) u_tap (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .en         (fire),
      .coef_we    (tap_we[k]),
      .coef_wdata (coef_wdata),
      .x_in       (x_in),
      .acc_in     (acc[k+1]),
      .acc_out    (acc[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       out_valid <= 1'b0;
    else if (clear)     out_valid <= 1'b0;
    else if (fire)      out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  always_comb res = sat_round(wide_t'(acc[0]), SHIFT, YW);

  assign y_out     = res.y[YW-1:0];
  assign sat_flag  = res.sat;
  assign unused_hi = ^res.y[WIDE_W-1:YW];

endmodule

// File: tb/tb_fir_tf_stream.sv
// Scoreboard bench for fir_tf_stream: three builds (8 taps SHIFT=0, 8 taps
// SHIFT=3, 5 taps SHIFT=0) share one stimulus stream and one reference model.
module tb_fir_tf_stream;

  logic              clk = 1'b0;
  logic              reset_n, clear, coef_we, in_valid, out_ready;
  logic [2:0]        coef_addr;
  logic signed [7:0] coef_wdata, x_in;
  logic              ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, sat_a, sat_b, sat_c;
  logic signed [15:0] y_a, y_b, y_c;

  fir_tf_stream #(.N_TAPS(8), .XW(8), .CW(8), .YW(16), .SHIFT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(ir_a), .x_in(x_in),
    .out_valid(ov_a), .out_ready(out_ready), .y_out(y_a), .sat_flag(sat_a));

  fir_tf_stream #(.N_TAPS(8), .XW(8), .CW(8), .YW(16), .SHIFT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(ir_b), .x_in(x_in),
    .out_valid(ov_b), .out_ready(out_ready), .y_out(y_b), .sat_flag(sat_b));

  fir_tf_stream #(.N_TAPS(5), .XW(8), .CW(8), .YW(16), .SHIFT(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(ir_c), .x_in(x_in),
    .out_valid(ov_c), .out_ready(out_ready), .y_out(y_c), .sat_flag(sat_c));

  initial forever #5 clk = ~clk;

  typedef struct packed {
    int y0; int s0; int y3; int s3; int y5; int s5;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   got[$];
  int   last_y0, last_s0, last_y3, last_s3;
  int   rmode = 0;
  int   cyc = 0;

  // Reference state: accepted samples with the coefficient set in force when
  // each one was accepted (products are formed on arrival).
  int   hx [8];
  int   hc8 [8][8];
  int   hc5 [8][8];
  int   mc8 [8];
  int   mc5 [8];
  bit   mvalid;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void round_sat(input longint acc, input int sh, output int y, output int s);
    longint v, d, q;
    d = longint'(1) << sh;
    v = acc + ((sh > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    s = 0;
    if (q > 32767) begin q = 32767; s = 1; end
    else if (q < -32768) begin q = -32768; s = 1; end
    y = int'(q);
  endfunction

  // Reference model: handshake, accept, expected output, coefficient updates.
  always @(negedge clk) begin : model
    bit     rdy, fire;
    longint a8, a5;
    exp_t   e;
    if (!reset_n) begin
      for (int j = 0; j < 8; j++) begin
        hx[j] = 0; mc8[j] = 0; mc5[j] = 0;
        for (int k = 0; k < 8; k++) begin hc8[j][k] = 0; hc5[j][k] = 0; end
      end
      mvalid = 1'b0;
      sb.delete();
    end else begin
      rdy = !clear && (!mvalid || out_ready);
      chk("in_ready", {ir_a, ir_b, ir_c}, {3{rdy}});
      chk("out_valid", {ov_a, ov_b, ov_c}, {3{mvalid}});
      fire = in_valid && rdy;
      if (clear) begin
        if (mvalid && !out_ready) void'(sb.pop_back());
        for (int j = 0; j < 8; j++) hx[j] = 0;
        mvalid = 1'b0;
      end else begin
        if (fire) begin
          for (int j = 7; j > 0; j--) begin
            hx[j] = hx[j-1]; hc8[j] = hc8[j-1]; hc5[j] = hc5[j-1];
          end
          hx[0] = int'(x_in); hc8[0] = mc8; hc5[0] = mc5;
          a8 = 0; a5 = 0;
          for (int k = 0; k < 8; k++) a8 += longint'(hx[k]) * hc8[k][k];
          for (int k = 0; k < 5; k++) a5 += longint'(hx[k]) * hc5[k][k];
          round_sat(a8, 0, e.y0, e.s0);
          round_sat(a8, 3, e.y3, e.s3);
          round_sat(a5, 0, e.y5, e.s5);
          sb.push_back(e);
          mvalid = 1'b1;
        end else if (out_ready) begin
          mvalid = 1'b0;
        end
      end
      if (coef_we) begin
        mc8[coef_addr] = int'(coef_wdata);
        if (coef_addr < 3'd5) mc5[coef_addr] = int'(coef_wdata);
      end
    end
  end

  // Monitor: pops the scoreboard on every output beat.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && ov_a && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got y=%0d, expected no beat (t=%0t)", y_a, $time);
      end else begin
        e = sb.pop_front();
        chk("y_s0", y_a, e.y0);   chk("sat_s0", sat_a, e.s0);
        chk("y_s3", y_b, e.y3);   chk("sat_s3", sat_b, e.s3);
        chk("y_n5", y_c, e.y5);   chk("sat_n5", sat_c, e.s5);
        got.push_back(int'(y_a));
        last_y0 = int'(y_a); last_s0 = int'(sat_a);
        last_y3 = int'(y_b); last_s3 = int'(sat_b);
      end
    end
  end

  // Downstream ready: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int x, input bit we = 1'b0, input int addr = 0,
                      input int wd = 0, input bit clr = 1'b0);
    int t;
    bit acc;
    t = 0;
    in_valid = 1'b1; x_in = 8'(x);
    coef_we = we; coef_addr = 3'(addr); coef_wdata = 8'(wd); clear = clr;
    do begin
      @(negedge clk); acc = ir_a;
      step();
      coef_we = 1'b0; clear = 1'b0; t++;
    end while (!acc && t < 64);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_wdata = 8'(val);
    step();
    coef_we = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || ov_a) && t < 300) begin step(); t++; end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic check_got(input string name, input int ev[$]);
    chk({name, "_count"}, got.size(), ev.size());
    for (int i = 0; i < ev.size() && i < got.size(); i++) chk(name, got[i], ev[i]);
    got.delete();
  endtask

  task automatic load_c1();
    int c1 [8];
    c1 = '{4, 12, 25, 34, 34, 25, 12, 4};
    for (int k = 0; k < 8; k++) wcoef(k, c1[k]);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ev_imp[$], ev_ramp[$], ev_wr[$], ev_zero[$];
    int r;
    ev_imp  = '{4, 12, 25, 34, 34, 25, 12, 4, 0};
    ev_ramp = '{508, 2032, 5207, 9525, 13843, 17018, 18542, 19050, 19050, 19050};
    ev_wr   = '{4, 12, 37, 59, 68, 59, 37, 16, 4};
    ev_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    reset_n = 1'b0; clear = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", y_a, 0); chk("reset_valid", ov_a, 0); chk("reset_sat", sat_a, 0);
    reset_n = 1'b1;
    step();

    // impulse response
    load_c1();
    got.delete();
    send(1); repeat (8) send(0);
    drain();
    check_got("impulse", ev_imp);

    // step response
    repeat (10) send(127);
    drain();
    check_got("step", ev_ramp);

    // step response under 1,0,0,1 backpressure
    repeat (8) send(0);
    drain(); got.delete();
    rmode = 1;
    repeat (10) send(127);
    drain();
    rmode = 0; out_ready = 1'b1;
    check_got("backpressure", ev_ramp);

    // saturation, and the same stream through the SHIFT=3 build
    for (int k = 0; k < 8; k++) wcoef(k, 127);
    repeat (10) send(-128);
    drain(); got.delete();
    chk("sat_min_y", last_y0, -32768); chk("sat_min_flag", last_s0, 1);
    chk("shift3_y", last_y3, -16256);  chk("shift3_flag", last_s3, 0);

    // coefficient write coinciding with a fire
    load_c1();
    repeat (8) send(0);
    drain(); got.delete();
    send(1, 1'b1, 0, 0); send(1); repeat (7) send(0);
    drain();
    check_got("coef_write", ev_wr);
    wcoef(6, 99);
    send(1); repeat (8) send(0);
    drain(); got.delete();

    // clear mid-stream, and a stalled output discarded by clear
    load_c1();
    repeat (5) send(127);
    pulse_clear();
    drain(); got.delete();
    rmode = 3; out_ready = 1'b0;
    send(127);
    pulse_clear();
    rmode = 0; out_ready = 1'b1;
    chk("clear_discard", ov_a, 0);
    send(1); repeat (8) send(0);
    drain();
    check_got("post_clear_impulse", ev_imp);

    // reset mid-stream
    repeat (3) send(50);
    #3 reset_n = 1'b0;
    #1;
    chk("midreset_valid", {ov_a, ov_b, ov_c}, 0);
    chk("midreset_y", y_a, 0);
    chk("midreset_y_s3", y_b, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    step(); got.delete();
    send(1); repeat (8) send(0);
    drain();
    check_got("post_reset_impulse", ev_zero);

    // randomized traffic
    for (int k = 0; k < 8; k++) wcoef(k, int'($urandom_range(0, 255)) - 128);
    rmode = 2;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0:       pulse_clear();
        1:       wcoef(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
        2:       step();
        3:       send(int'($urandom_range(0, 255)) - 128, 1'b0, 0, 0, 1'b1);
        4:       send(int'($urandom_range(0, 255)) - 128, 1'b1,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
        default: send(int'($urandom_range(0, 255)) - 128);
      endcase
    end
    rmode = 0; out_ready = 1'b1;
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
